ps2_mouse_receiver: RTL and testbench

PS2_MOUSE_RECEIVER -- requirements
Module: ps2_mouse_receiver

---
 rtl/mouse_pkg.sv | 30 +++
 rtl/ps2_mouse_receiver_if.sv | 13 +
 rtl/ps2_byte_rx.sv | 109 ++++++++++
 rtl/ps2_mouse_receiver.sv | 109 ++++++++++
 tb/tb_ps2_mouse_receiver.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared screen limits, byte-0 field positions, byte FSM states, clamp helper
package mouse_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int B0_LEFT    = 0;
  localparam int B0_RIGHT   = 1;
  localparam int B0_MIDDLE  = 2;
  localparam int B0_ALWAYS1 = 3;
  localparam int B0_XSIGN   = 4;
  localparam int B0_YSIGN   = 5;
  localparam int B0_XOVF    = 6;
  localparam int B0_YOVF    = 7;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  // Negative results pin to 0, results beyond max_v pin to max_v.
  function automatic logic [9:0] clamp_pos(input logic signed [10:0] v, input logic [9:0] max_v);
    logic [9:0] r;
    if (v[10])
      r = '0;
    else if (v > $signed({1'b0, max_v}))
      r = max_v;
    else
      r = v[9:0];
    return r;
  endfunction

endpackage

// File: rtl/ps2_mouse_receiver_if.sv
// rtl/ps2_mouse_receiver_if.sv - decoded mouse report bus (position, buttons, status pulses)
interface ps2_mouse_receiver_if;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       btn_left;
  logic       btn_right;
  logic       btn_middle;
  logic       packet_valid;
  logic       frame_err;

  modport master (output x_pos, y_pos, btn_left, btn_right, btn_middle, packet_valid, frame_err);
  modport slave  (input  x_pos, y_pos, btn_left, btn_right, btn_middle, packet_valid, frame_err);
endinterface

// File: rtl/ps2_byte_rx.sv
// rtl/ps2_byte_rx.sv - PS/2 line synchronizers, falling-edge detect, byte FSM with timeout
// Parity is enforced only when PS2_MOUSE_PARITY_CHECK_EN is defined.
import mouse_pkg::*;

module ps2_byte_rx #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_e state_q, state_d;
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic [TW-1:0] timer_q;
  logic          fall, bit_in, timeout, parity_ok;

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  assign bit_in  = data_sync_q[1];
  assign timeout = (state_q != IDLE) && !fall && (timer_q == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_MOUSE_PARITY_CHECK_EN
  logic parity_q;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      parity_q <= 1'b0;
    else if (fall && state_q == PARITY)
      parity_q <= bit_in;
  end
  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout)
      state_d = IDLE;
    else if (fall) begin
      case (state_q)
        IDLE:    if (!bit_in) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_valid = 1'b0;
    byte_err   = timeout;
    if (fall && state_q == STOP) begin
      if (bit_in && parity_ok)
        byte_valid = 1'b1;
      else
        byte_err = 1'b1;
    end
  end

  // Timer counts only idle-line cycles inside a frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
    end else begin
      if (state_q == IDLE || fall || timeout)
        timer_q <= '0;
      else
        timer_q <= timer_q + 1'b1;
      if (fall && state_q == IDLE)
        bit_cnt_q <= '0;
      if (fall && state_q == DATA) begin
        shift_q   <= {bit_in, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/ps2_mouse_receiver.sv
// rtl/ps2_mouse_receiver.sv - PS/2 mouse packet assembler and cursor tracker (top)
// Optional parity enforcement in ps2_byte_rx: PS2_MOUSE_PARITY_CHECK_EN.
import mouse_pkg::*;

module ps2_mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int X_INIT         = 360,
  parameter int Y_INIT         = 200
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_mouse_receiver_if.master rpt
);
  localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);

  logic [7:0] byte_data;
  logic       byte_valid, byte_err;

  ps2_byte_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_byte_rx (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  logic [1:0] idx_q, idx_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [2:0] btn_q, btn_d;
  logic       pv_q, pv_d, fe_q, fe_d;
  logic signed [10:0] dx, dy, x_new, y_new;

  // Sign bits for both deltas live in byte 0; dy arrives live as the third byte.
  assign dx    = {{2{b0_q[B0_XSIGN]}}, b0_q[B0_XSIGN], b1_q};
  assign dy    = {{2{b0_q[B0_YSIGN]}}, b0_q[B0_YSIGN], byte_data};
  assign x_new = $signed({1'b0, x_q}) + dx;
  assign y_new = $signed({1'b0, y_q}) - dy;

  always_comb begin
    idx_d = idx_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    x_d   = x_q;
    y_d   = y_q;
    btn_d = btn_q;
    pv_d  = 1'b0;
    fe_d  = byte_err;
    if (byte_err)
      idx_d = 2'd0;
    else if (byte_valid) begin
      case (idx_q)
        2'd0: if (byte_data[B0_ALWAYS1]) begin
          b0_d  = byte_data;
          idx_d = 2'd1;
        end
        2'd1: begin
          b1_d  = byte_data;
          idx_d = 2'd2;
        end
        default: begin
          idx_d = 2'd0;
          pv_d  = 1'b1;
          btn_d = {b0_q[B0_MIDDLE], b0_q[B0_RIGHT], b0_q[B0_LEFT]};
          if (!(b0_q[B0_XOVF] || b0_q[B0_YOVF])) begin
            x_d = clamp_pos(x_new, X_MAX);
            y_d = clamp_pos(y_new, Y_MAX);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx_q <= '0;
      b0_q  <= '0;
      b1_q  <= '0;
      x_q   <= 10'(X_INIT);
      y_q   <= 10'(Y_INIT);
      btn_q <= '0;
      pv_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      x_q   <= x_d;
      y_q   <= y_d;
      btn_q <= btn_d;
      pv_q  <= pv_d;
      fe_q  <= fe_d;
    end
  end

  assign rpt.x_pos        = x_q;
  assign rpt.y_pos        = y_q;
  assign rpt.btn_left     = btn_q[0];
  assign rpt.btn_right    = btn_q[1];
  assign rpt.btn_middle   = btn_q[2];
  assign rpt.packet_valid = pv_q;
  assign rpt.frame_err    = fe_q;

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// tb/tb_ps2_mouse_receiver.sv - directed self-checking bench for ps2_mouse_receiver
module tb_ps2_mouse_receiver;
  localparam int TIMEOUT = 5000;
  localparam int HALF    = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_mouse_receiver_if mif();

  ps2_mouse_receiver #(.TIMEOUT_CYCLES(TIMEOUT), .X_INIT(360), .Y_INIT(200)) dut (
    .clk_in  (clk),
    .rst_in  (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rpt     (mif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;
  int rst_pulses = 0;
  int pv_x = -1;
  int pv_y = -1;
  int pv0, fe0;

  always @(negedge clk) begin
    if (rst) begin
      if (mif.packet_valid || mif.frame_err) rst_pulses++;
    end else begin
      if (mif.packet_valid) begin
        pv_cnt++;
        pv_x = int'(mif.x_pos);
        pv_y = int'(mif.y_pos);
      end
      if (mif.frame_err) fe_cnt++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(stop_b);
    ps2_data = 1'b1;
    cyc(2 * HALF);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_frame(a, 1'b0, 1'b1);
    send_frame(b, 1'b0, 1'b1);
    send_frame(c, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(5);
    rst = 1'b0;
    cyc(5);
  endtask

  task automatic mark();
    pv0 = pv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    cyc(3);
    chk("rst_x", int'(mif.x_pos), 360);
    chk("rst_y", int'(mif.y_pos), 200);
    chk("rst_btn", int'({mif.btn_middle, mif.btn_right, mif.btn_left}), 0);
    chk("rst_pv", int'(mif.packet_valid), 0);
    chk("rst_fe", int'(mif.frame_err), 0);
    rst = 1'b0;
    cyc(5);

    mark();
    send_pkt(8'h08, 8'h0A, 8'h05);
    chk("basic_x", int'(mif.x_pos), 370);
    chk("basic_y", int'(mif.y_pos), 195);
    chk("basic_pv_cnt", pv_cnt - pv0, 1);
    chk("basic_fe_cnt", fe_cnt - fe0, 0);
    chk("basic_pv_x", pv_x, 370);
    chk("basic_pv_y", pv_y, 195);

    do_reset();
    mark();
    send_pkt(8'h18, 8'h00, 8'h00);
    chk("neg1_x", int'(mif.x_pos), 104);
    chk("neg1_y", int'(mif.y_pos), 200);
    send_pkt(8'h18, 8'h00, 8'h00);
    chk("neg2_x", int'(mif.x_pos), 0);
    chk("neg2_y", int'(mif.y_pos), 200);
    chk("neg_pv_cnt", pv_cnt - pv0, 2);

    mark();
    send_pkt(8'h49, 8'h7F, 8'h7F);
    chk("ovf_left", int'(mif.btn_left), 1);
    chk("ovf_right", int'(mif.btn_right), 0);
    chk("ovf_x", int'(mif.x_pos), 0);
    chk("ovf_y", int'(mif.y_pos), 200);
    chk("ovf_pv_cnt", pv_cnt - pv0, 1);

    // Reset in the middle of a byte, with the PS/2 clock held low.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_clk = 1'b0;
    cyc(3);
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(4);
    chk("mid_rst_x", int'(mif.x_pos), 360);
    chk("mid_rst_y", int'(mif.y_pos), 200);
    chk("mid_rst_btn", int'({mif.btn_middle, mif.btn_right, mif.btn_left}), 0);
    chk("rst_pulses", rst_pulses, 0);
    rst = 1'b0;
    cyc(5);
    mark();
    send_pkt(8'h08, 8'h0A, 8'h05);
    chk("post_rst_x", int'(mif.x_pos), 370);
    chk("post_rst_y", int'(mif.y_pos), 195);
    chk("post_rst_pv_cnt", pv_cnt - pv0, 1);

    do_reset();
    send_pkt(8'h2E, 8'hFF, 8'h00);
    chk("pos1_x", int'(mif.x_pos), 615);
    chk("pos1_y", int'(mif.y_pos), 456);
    chk("pos1_btn", int'({mif.btn_middle, mif.btn_right, mif.btn_left}), 6);
    send_pkt(8'h2E, 8'hFF, 8'h00);
    chk("pos2_x", int'(mif.x_pos), 639);
    chk("pos2_y", int'(mif.y_pos), 479);

    mark();
    send_frame(8'h08, 1'b0, 1'b0);
    chk("stop_fe_cnt", fe_cnt - fe0, 1);
    chk("stop_pv_cnt", pv_cnt - pv0, 0);

    do_reset();
    mark();
    send_frame(8'h08, 1'b0, 1'b1);
    send_frame(8'h0A, 1'b1, 1'b1);
    send_frame(8'h05, 1'b0, 1'b1);
`ifdef PS2_MOUSE_PARITY_CHECK_EN
    chk("par_fe_cnt", fe_cnt - fe0, 1);
    chk("par_pv_cnt", pv_cnt - pv0, 0);
    chk("par_x", int'(mif.x_pos), 360);
`else
    chk("par_fe_cnt", fe_cnt - fe0, 0);
    chk("par_pv_cnt", pv_cnt - pv0, 1);
    chk("par_x", int'(mif.x_pos), 370);
`endif

    do_reset();
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(TIMEOUT + 1 + 10);
    chk("tmo_fe_cnt", fe_cnt - fe0, 1);
    send_frame(8'h00, 1'b0, 1'b1);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk("tmo_x", int'(mif.x_pos), 361);
    chk("tmo_y", int'(mif.y_pos), 199);
    chk("tmo_pv_cnt", pv_cnt - pv0, 1);
    chk("tmo_fe_after", fe_cnt - fe0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
